snake_step_scheduler: RTL and testbench
=======================================

Name: snake_step_scheduler

Overview:
- Game-sequencing controller between the keyboard decoder and the snake field datapath.
- Owns the game state machine (idle/run/pause/over) and issues the `start` pulse and paced `step` requests to the field, with a step/ack handshake.
- Commits the snake direction once per step and keeps score and speed level; the step period shortens as the level rises.

Parameters:
- TICK_BASE, 12000000: step period in clk cycles at level 0.
- TICK_DEC, 1000000: period reduction per level.
- MIN_PERIOD, 2000000: floor on the step period.
- FOODS_PER_LEVEL, 5: foods eaten per level increment.
- MAX_LEVEL, 9: level saturation value.
- SCORE_W, 10: score width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_start  in  1  one-cycle pulse: start / restart
- key_pause  in  1  one-cycle pulse: toggle pause
- dir_valid  in  1  one-cycle pulse: new direction requested
- dir_req  in  2  requested direction: 0=right, 1=up, 2=left, 3=down
- step_ack  in  1  field finished the requested step
- step_ate  in  1  qualified by step_ack: food eaten on this step
- snake_alive  in  1  field status; 0 means collision
- start  out  1  one-cycle field (re)initialise pulse
- step  out  1  step request; held until step_ack
- snake_dir  out  2  committed direction
- is_running  out  1  high in RUN and WAIT_ACK
- game_over  out  1  high in OVER
- score  out  SCORE_W  foods eaten, saturating
- level  out  4  current speed level

Behaviour:
- Reset (async, rst_n=0): state=IDLE; start=0, step=0, snake_dir=0, pending dir=0, is_running=0, game_over=0, score=0, level=0, period counter=0, pause-pending=0. Reset asserted mid-step drops step immediately; no ack is awaited afterward.
- Period: period = max(TICK_BASE − level·TICK_DEC, MIN_PERIOD). Compute it without underflow (subtraction clamped). Counter width is $clog2(TICK_BASE).
- IDLE: key_start → START.
- START: lasts one cycle with start=1. Clears score, level and counter; snake_dir and pending dir become 0. Next state RUN.
- RUN:
  - Counter increments each cycle.
  - When counter == period−1: counter clears, snake_dir takes the pending dir, step rises on the next cycle, state goes to WAIT_ACK.
  - key_pause → PAUSE; the counter holds its value.
  - snake_alive=0 → OVER; this has priority over step issue and pause.
- WAIT_ACK:
  - step=1 until the cycle step_ack=1 is sampled; step=0 the following cycle, then state RUN with counter=0.
  - If step_ate=1 with the ack: score+1, saturating at all-ones.
  - On every FOODS_PER_LEVEL-th food: level+1, saturating at MAX_LEVEL. The new period applies from the next step.
  - A key_pause seen in WAIT_ACK sets pause-pending; the state goes to PAUSE after the ack instead of RUN.
  - snake_alive=0 is acted on only after the ack.
- PAUSE: key_pause → RUN, resuming the held count. key_start → START. is_running=0.
- OVER: game_over=1; key_start → START.
- Direction:
  - dir_valid in any state except IDLE/OVER updates the pending dir, unless dir_req == snake_dir ^ 2'b10 (reversal); reversals are ignored.
  - The last valid request before the commit wins.
  - Pending and committed dir are compared against the committed snake_dir, not against the previous pending dir.
- Simultaneous events in one RUN cycle, in priority order: snake_alive=0 > key_start (ignored in RUN) > key_pause > step issue. Pause on the terminal-count cycle suppresses the step and clears the counter.
- Stray inputs: step_ack outside WAIT_ACK is ignored. step_ate without step_ack is ignored.

Test Plan:
- Bench parameters: TICK_BASE=10, TICK_DEC=2, MIN_PERIOD=4, FOODS_PER_LEVEL=2, MAX_LEVEL=9; step_ack returned 2 cycles after step.
- Basic stepping: reset, key_start → start high exactly 1 cycle; first step rises 10 cycles into RUN; step stays high until ack then drops; steps repeat every 10 cycles + handshake; is_running=1.
- Direction: dir_req=2 while snake_dir=0 → ignored. dir_req=1 then dir_req=3 in the same period → snake_dir=3 at the next step, unchanged before it.
- Speed-up: ack with step_ate 2 times → score=2, level=1, period 8 cycles. 4 more foods → level=3, period clamps to 4. Period stays 4 up to level 9; level saturates at 9.
- Pause: key_pause at count 5 → no step while paused. Second key_pause → step after 5 more cycles. key_pause during WAIT_ACK → PAUSE after the ack.
- Death and restart: snake_alive=0 in RUN → game_over=1, is_running=0, no further steps. key_start → start pulse, score=0, level=0, snake_dir=0.
- Async reset: rst_n=0 while step=1 → all outputs zero immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/snake_step_scheduler.sv
// rtl/snake_step_scheduler.sv - game sequencer: start pulse, paced step/ack, direction commit, score and level
module snake_step_scheduler #(
    parameter int TICK_BASE       = 12000000,
    parameter int TICK_DEC        = 1000000,
    parameter int MIN_PERIOD      = 2000000,
    parameter int FOODS_PER_LEVEL = 5,
    parameter int MAX_LEVEL       = 9,
    parameter int SCORE_W         = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    input  logic               step_ack,
    input  logic               step_ate,
    input  logic               snake_alive,
    output logic               start,
    output logic               step,
    output logic [1:0]         snake_dir,
    output logic               is_running,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level
);

    localparam int CW = $clog2(TICK_BASE);
    localparam int FW = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RUN, S_WAIT_ACK, S_PAUSE, S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               step_q, step_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_q, pend_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         level_q, level_d;
    logic [FW-1:0]      food_q, food_d;
    logic               pp_q, pp_d;

    logic [31:0] dec_amt;
    logic [31:0] period;
    logic        terminal;

    // Subtraction is only taken when it stays above the floor, so it cannot wrap.
    always_comb begin
        dec_amt = 32'(level_q) * 32'(TICK_DEC);
        if (dec_amt + 32'(MIN_PERIOD) < 32'(TICK_BASE)) begin
            period = 32'(TICK_BASE) - dec_amt;
        end else begin
            period = 32'(MIN_PERIOD);
        end
        terminal = (32'(cnt_q) == period - 32'd1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        score_d = score_q;
        level_d = level_q;
        food_d  = food_q;
        pp_d    = pp_q;

        // Reversal is judged against the committed direction, not the pending one.
        if (dir_valid && state_q != S_IDLE && state_q != S_OVER && dir_req != (dir_q ^ 2'b10)) begin
            pend_d = dir_req;
        end

        case (state_q)
            S_IDLE: begin
                if (key_start) state_d = S_START;
            end
            S_START: begin
                score_d = '0;
                level_d = '0;
                food_d  = '0;
                cnt_d   = '0;
                dir_d   = 2'd0;
                pend_d  = 2'd0;
                pp_d    = 1'b0;
                step_d  = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!snake_alive) begin
                    state_d = S_OVER;
                end else if (key_pause) begin
                    state_d = S_PAUSE;
                    if (terminal) cnt_d = '0;
                end else if (terminal) begin
                    cnt_d   = '0;
                    dir_d   = pend_q;
                    step_d  = 1'b1;
                    state_d = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (key_pause) pp_d = 1'b1;
                if (step_ack) begin
                    step_d = 1'b0;
                    cnt_d  = '0;
                    pp_d   = 1'b0;
                    if (step_ate) begin
                        if (score_q != '1) score_d = score_q + 1'b1;
                        if (food_q == FW'(FOODS_PER_LEVEL - 1)) begin
                            food_d = '0;
                            if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
                        end else begin
                            food_d = food_q + 1'b1;
                        end
                    end
                    if (!snake_alive) begin
                        state_d = S_OVER;
                    end else if (pp_q || key_pause) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_PAUSE: begin
                if (key_start) begin
                    state_d = S_START;
                end else if (key_pause) begin
                    state_d = S_RUN;
                end
            end
            S_OVER: begin
                if (key_start) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 2'd0;
            pend_q  <= 2'd0;
            score_q <= '0;
            level_q <= '0;
            food_q  <= '0;
            pp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            level_q <= level_d;
            food_q  <= food_d;
            pp_q    <= pp_d;
        end
    end

    assign start      = (state_q == S_START);
    assign step       = step_q;
    assign snake_dir  = dir_q;
    assign is_running = (state_q == S_RUN) || (state_q == S_WAIT_ACK);
    assign game_over  = (state_q == S_OVER);
    assign score      = score_q;
    assign level      = level_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// tb/tb_snake_step_scheduler.sv - randomized and directed bench for snake_step_scheduler against a game-rule model
module tb_snake_step_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_start = 1'b0, key_pause = 1'b0, dir_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       step_ack = 1'b0, step_ate = 1'b0, snake_alive = 1'b1;
    logic       stray_ack = 1'b0;
    logic       start, step, is_running, game_over;
    logic [1:0] snake_dir;
    logic [9:0] score;
    logic [3:0] level;
    logic [19:0] dut_vec;

    int checks = 0;
    int errors = 0;

    snake_step_scheduler #(
        .TICK_BASE(10), .TICK_DEC(2), .MIN_PERIOD(4),
        .FOODS_PER_LEVEL(2), .MAX_LEVEL(9), .SCORE_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_pause(key_pause),
        .dir_valid(dir_valid), .dir_req(dir_req), .step_ack(step_ack),
        .step_ate(step_ate), .snake_alive(snake_alive), .start(start), .step(step),
        .snake_dir(snake_dir), .is_running(is_running), .game_over(game_over),
        .score(score), .level(level)
    );

    always #5 clk = ~clk;

    assign dut_vec = {start, step, snake_dir, is_running, game_over, score, level};

    // Game model: phase by name, level derived from total foods eaten.
    string m_phase;
    int    m_cnt, m_dir, m_pend, m_score, m_foods, m_age;
    bit    m_step, m_pp;

    function automatic int mlevel();
        return (m_foods / 2 > 9) ? 9 : m_foods / 2;
    endfunction

    function automatic int mperiod(int lvl);
        return (10 - 2 * lvl > 4) ? 10 - 2 * lvl : 4;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic s, r, o;
        s = (m_phase == "start");
        r = (m_phase == "run") || (m_phase == "wait");
        o = (m_phase == "over");
        return {s, m_step, 2'(m_dir), r, o, 10'(m_score), 4'(mlevel())};
    endfunction

    task automatic model_reset();
        m_phase = "idle";
        m_cnt = 0; m_dir = 0; m_pend = 0; m_score = 0; m_foods = 0; m_age = 0;
        m_step = 0; m_pp = 0;
    endtask

    task automatic model_edge();
        string nph;
        int    per, old_pend;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nph = m_phase;
        old_pend = m_pend;
        per = mperiod(mlevel());
        if (dir_valid && m_phase != "idle" && m_phase != "over" && int'(dir_req) != (m_dir ^ 2))
            m_pend = int'(dir_req);
        if (m_step) m_age++;
        if (m_phase == "idle") begin
            if (key_start) nph = "start";
        end else if (m_phase == "start") begin
            m_score = 0; m_foods = 0; m_cnt = 0; m_dir = 0; m_pend = 0; m_pp = 0; m_step = 0;
            nph = "run";
        end else if (m_phase == "run") begin
            if (!snake_alive) nph = "over";
            else if (key_pause) begin
                nph = "pause";
                if (m_cnt == per - 1) m_cnt = 0;
            end else if (m_cnt == per - 1) begin
                m_cnt = 0; m_dir = old_pend; m_step = 1; m_age = 0; nph = "wait";
            end else m_cnt++;
        end else if (m_phase == "wait") begin
            if (key_pause) m_pp = 1;
            if (step_ack) begin
                m_step = 0; m_cnt = 0;
                if (step_ate) begin
                    m_foods++;
                    m_score = (m_score >= 1023) ? 1023 : m_score + 1;
                end
                nph = !snake_alive ? "over" : (m_pp ? "pause" : "run");
                m_pp = 0;
            end
        end else if (m_phase == "pause") begin
            if (key_start) nph = "start";
            else if (key_pause) nph = "run";
        end else if (m_phase == "over") begin
            if (key_start) nph = "start";
        end
        m_phase = nph;
    endtask

    // Field responder acks two cycles after step rises; inputs change 1 ns after the edge.
    task automatic tick();
        step_ack = (m_step && m_age == 2) || stray_ack;
        @(posedge clk);
        model_edge();
        #1;
        key_start = 0; key_pause = 0; dir_valid = 0; stray_ack = 0; step_ack = 0;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        while (step !== 1'b1 && n < 100) begin tick(); n++; end
        if (step !== 1'b1) n = -1;
    endtask

    task automatic wait_low(output int n);
        n = 0;
        while (step !== 1'b0 && n < 100) begin tick(); n++; end
        if (step !== 1'b0) n = -1;
    endtask

    task automatic apply_reset();
        key_start = 0; key_pause = 0; dir_valid = 0; step_ate = 0; snake_alive = 1; stray_ack = 0;
        rst_n = 0;
        model_reset();
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        tick(); tick();
        checks++;
        if (dut_vec !== 20'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", dut_vec); end
        rst_n = 1;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL idle_hold got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_basic();
        int n;
        dir_valid = 1; dir_req = 2'd1; tick();
        key_start = 1; tick();
        checks++;
        if (start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b want 1", start); end
        tick();
        checks++;
        if ({start, is_running} !== 2'b01) begin errors++; $display("FAIL start_one_cycle got %b want 01", {start, is_running}); end
        wait_step(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL first_step_delay got %0d want 10", n); end
        checks++;
        if (snake_dir !== 2'd0) begin errors++; $display("FAIL idle_dir_ignored got %0d want 0", snake_dir); end
        tick(); tick();
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL step_held got %b want 1", step); end
        tick();
        checks++;
        if ({step, is_running} !== 2'b01) begin errors++; $display("FAIL step_drop got %b want 01", {step, is_running}); end
        wait_step(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL step_repeat got %0d want 10", n); end
        wait_low(n);
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_model got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_direction();
        int n;
        dir_valid = 1; dir_req = 2'd2; tick();
        dir_valid = 1; dir_req = 2'd1; tick();
        dir_valid = 1; dir_req = 2'd3; tick();
        checks++;
        if (snake_dir !== 2'd0) begin errors++; $display("FAIL dir_before_commit got %0d want 0", snake_dir); end
        wait_step(n);
        checks++;
        if (snake_dir !== 2'd3) begin errors++; $display("FAIL dir_last_wins got %0d want 3", snake_dir); end
        wait_low(n);
        dir_valid = 1; dir_req = 2'd1; tick();
        wait_step(n);
        checks++;
        if (snake_dir !== 2'd3) begin errors++; $display("FAIL dir_reversal got %0d want 3", snake_dir); end
        wait_low(n);
        dir_valid = 1; dir_req = 2'd2; tick();
        wait_step(n);
        checks++;
        if (snake_dir !== 2'd2) begin errors++; $display("FAIL dir_turn got %0d want 2", snake_dir); end
        wait_low(n);
    endtask

    task automatic test_speedup();
        int n, exp_per, exp_lvl;
        apply_reset();
        key_start = 1; tick(); tick();
        step_ate = 1;
        for (int k = 0; k < 24; k++) begin
            exp_lvl = (k / 2 > 9) ? 9 : k / 2;
            exp_per = (10 - 2 * exp_lvl > 4) ? 10 - 2 * exp_lvl : 4;
            wait_step(n);
            checks++;
            if (n !== exp_per) begin errors++; $display("FAIL period_k%0d got %0d want %0d", k, n, exp_per); end
            wait_low(n);
            exp_lvl = ((k + 1) / 2 > 9) ? 9 : (k + 1) / 2;
            checks++;
            if ({score, level} !== {10'(k + 1), 4'(exp_lvl)})
                begin errors++; $display("FAIL score_level_k%0d got %0d/%0d want %0d/%0d", k, score, level, k + 1, exp_lvl); end
        end
        step_ate = 0;
        dir_valid = 1; dir_req = 2'd1; tick();
        wait_step(n); wait_low(n);
    endtask

    task automatic test_death_restart();
        int hits;
        snake_alive = 0; tick(); snake_alive = 1;
        checks++;
        if ({game_over, is_running} !== 2'b10) begin errors++; $display("FAIL death got %b want 10", {game_over, is_running}); end
        hits = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (step === 1'b1) hits++; end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL no_step_over got %0d want 0", hits); end
        key_start = 1; tick();
        checks++;
        if (start !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b want 1", start); end
        tick();
        checks++;
        if ({score, level, snake_dir, is_running, game_over} !== 18'b1_0)
            begin errors++; $display("FAIL restart_clear got %0d/%0d/%0d/%b want 0/0/0/1", score, level, snake_dir, is_running); end
    endtask

    task automatic test_pause();
        int n, hits;
        for (int i = 0; i < 5; i++) tick();
        key_pause = 1; tick();
        checks++;
        if (is_running !== 1'b0) begin errors++; $display("FAIL pause_enter got %b want 0", is_running); end
        hits = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (step === 1'b1) hits++; end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL paused_step got %0d want 0", hits); end
        key_pause = 1; tick();
        wait_step(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL resume_count got %0d want 5", n); end
        key_pause = 1; tick(); tick(); tick();
        checks++;
        if ({step, is_running, game_over} !== 3'b000) begin errors++; $display("FAIL pause_after_ack got %b want 000", {step, is_running, game_over}); end
        hits = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (step === 1'b1) hits++; end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL pending_pause_step got %0d want 0", hits); end
        key_pause = 1; tick();
        wait_step(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL resume_after_ack got %0d want 10", n); end
        wait_low(n);
        for (int i = 0; i < 9; i++) tick();
        key_pause = 1; tick();
        checks++;
        if ({step, is_running} !== 2'b00) begin errors++; $display("FAIL pause_terminal got %b want 00", {step, is_running}); end
        key_pause = 1; tick();
        wait_step(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL terminal_cleared got %0d want 10", n); end
        wait_low(n);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            key_start   = ($urandom_range(0, 39) == 0);
            key_pause   = ($urandom_range(0, 29) == 0);
            dir_valid   = ($urandom_range(0, 3) == 0);
            dir_req     = 2'($urandom_range(0, 3));
            step_ate    = 1'($urandom_range(0, 1));
            snake_alive = ($urandom_range(0, 299) != 0);
            stray_ack   = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_c%0d got %h want %h", i, dut_vec, exp_vec()); end
        end
        snake_alive = 1; step_ate = 0;
    endtask

    task automatic test_async_reset();
        int n, hits;
        apply_reset();
        key_start = 1; tick(); tick();
        wait_step(n);
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL async_setup got %b want 1", step); end
        #2 rst_n = 0;
        #1;
        checks++;
        if (dut_vec !== 20'd0) begin errors++; $display("FAIL async_reset got %h want 0", dut_vec); end
        model_reset();
        tick();
        rst_n = 1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (step === 1'b1) hits++; end
        checks++;
        if (hits !== 0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset_idle got %0d/%h want 0/%h", hits, dut_vec, exp_vec()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_direction();
        test_speedup();
        test_death_restart();
        test_pause();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
